rgbled_seq: RTL and testbench

Frame sequencer directly upstream of ws281x_drv. Holds a per-LED colour table for the on-board RGB LED chain, written by the system bus or by fixed top-level logic. On request it streams the table to the driver over its valid/ack/last handshake. After each frame it enforces the WS281x latch gap before another frame may start.

---
 rtl/rgbled_seq.sv | 158 +++++++++++++++
 tb/tb_rgbled_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgbled_seq.sv
// Frame sequencer for a WS281x LED chain: holds the per-LED colour table and
// streams it in GRB order to ws281x_drv, then enforces the latch gap.
module rgbled_seq #(
  parameter int unsigned NumLeds     = 2,
  parameter int unsigned LatchCycles = 7500,
  parameter bit          AutoRefresh = 1'b0,
  localparam int unsigned IdxW       = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic [23:0]     wr_data_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            go_o,
  output logic [23:0]     data_o,
  output logic            data_valid_o,
  output logic            data_last_o,
  input  logic            data_ack_i,
  input  logic            drv_idle_i
);

  localparam int unsigned CntW = (LatchCycles > 1) ? $clog2(LatchCycles) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumLeds - 1);
  localparam logic [CntW-1:0] CntInit = CntW'(LatchCycles - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DRAIN,
    ST_LATCH
  } state_e;

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [23:0]       table_q [NumLeds];
  logic [23:0]       table_d [NumLeds];
  logic [23:0]       data_q, data_d;
  logic              go_q, go_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;

  logic              wr_ok;
  logic              load;
  logic [IdxW-1:0]   load_idx;
  logic [23:0]       load_raw;

  assign wr_ok = wr_en_i && (32'(wr_idx_i) < NumLeds);

  // Colour table update; out-of-range indices are dropped.
  always_comb begin
    table_d = table_q;
    if (wr_ok) begin
      table_d[wr_idx_i] = wr_data_i;
    end
  end

  // Word about to be loaded, with write-first bypass for the same index.
  always_comb begin
    load_idx = (state_q == ST_IDLE) ? '0 : idx_q + IdxW'(1);
    load_raw = (wr_ok && (wr_idx_i == load_idx)) ? wr_data_i : table_q[load_idx];
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d   = ST_SEND;
          idx_d     = '0;
          pending_d = 1'b0;
          load      = 1'b1;
        end
      end
      ST_SEND: begin
        if (data_ack_i) begin
          if (last_q) begin
            state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + IdxW'(1);
            load  = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (drv_idle_i) begin
          cnt_d   = CntInit;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      data_d = {load_raw[15:8], load_raw[23:16], load_raw[7:0]};
    end

    // A request landing on the IDLE->SEND edge re-arms one more frame.
    if (start_i || (AutoRefresh && wr_ok)) begin
      pending_d = 1'b1;
    end

    valid_d = (state_d == ST_SEND);
    go_d    = (state_d == ST_SEND) || (state_d == ST_DRAIN);
    busy_d  = (state_d != ST_IDLE);
    last_d  = (state_d == ST_SEND) && (idx_d == LastIdx);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      table_q   <= '{default: '0};
      data_q    <= '0;
      go_q      <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      table_q   <= table_d;
      data_q    <= data_d;
      go_q      <= go_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_o       = busy_q;
  assign go_o         = go_q;
  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign data_last_o  = last_q;

endmodule

// File: tb/tb_rgbled_seq.sv
// Directed bench for rgbled_seq: a 2-LED manual-start instance and a
// 1-LED auto-refresh instance, with the driver handshake played by hand.
module tb_rgbled_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n;

  logic        a_rst, a_wr_en, a_start, a_ack, a_idle;
  logic [0:0]  a_wr_idx;
  logic [23:0] a_wr_data, a_data;
  logic        a_busy, a_go, a_valid, a_last;

  logic        b_rst, b_wr_en, b_start, b_ack, b_idle;
  logic [0:0]  b_wr_idx;
  logic [23:0] b_wr_data, b_data;
  logic        b_busy, b_go, b_valid, b_last;

  rgbled_seq #(.NumLeds(2), .LatchCycles(10), .AutoRefresh(1'b0)) u_a (
    .clk_i(clk), .rst_i(a_rst), .wr_en_i(a_wr_en), .wr_idx_i(a_wr_idx),
    .wr_data_i(a_wr_data), .start_i(a_start), .busy_o(a_busy), .go_o(a_go),
    .data_o(a_data), .data_valid_o(a_valid), .data_last_o(a_last),
    .data_ack_i(a_ack), .drv_idle_i(a_idle)
  );

  rgbled_seq #(.NumLeds(1), .LatchCycles(3), .AutoRefresh(1'b1)) u_b (
    .clk_i(clk), .rst_i(b_rst), .wr_en_i(b_wr_en), .wr_idx_i(b_wr_idx),
    .wr_data_i(b_wr_data), .start_i(b_start), .busy_o(b_busy), .go_o(b_go),
    .data_o(b_data), .data_valid_o(b_valid), .data_last_o(b_last),
    .data_ack_i(b_ack), .drv_idle_i(b_idle)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [0:0] idx, input logic [23:0] d);
    a_wr_en = 1'b1; a_wr_idx = idx; a_wr_data = d;
    step();
    a_wr_en = 1'b0;
  endtask

  task automatic a_start_frame();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    step();
  endtask

  // Ack every word, report drain idle, and wait out the latch gap.
  task automatic a_finish_frame();
    int k = 0;
    while (a_valid && k < 8) begin
      a_ack = 1'b1;
      step();
      k++;
    end
    a_ack = 1'b0;
    check("ff_valid_drop", 32'(a_valid), 32'd0);
    a_idle = 1'b1;
    step();
    a_idle = 1'b0;
    k = 0;
    while (a_busy && k < 50) begin
      step();
      k++;
    end
    check("ff_busy_fall", 32'(a_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    a_rst = 1'b1; a_wr_en = 1'b0; a_wr_idx = '0; a_wr_data = '0;
    a_start = 1'b0; a_ack = 1'b0; a_idle = 1'b0;
    b_rst = 1'b1; b_wr_en = 1'b0; b_wr_idx = '0; b_wr_data = '0;
    b_start = 1'b0; b_ack = 1'b0; b_idle = 1'b0;
    step();
    step();
    a_rst = 1'b0;
    b_rst = 1'b0;

    check("rst_busy",  32'(a_busy),  32'd0);
    check("rst_go",    32'(a_go),    32'd0);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_last",  32'(a_last),  32'd0);
    check("rst_data",  32'(a_data),  32'd0);
    check("rst_b_busy", 32'(b_busy), 32'd0);

    // Basic two-word frame, latency and latch gap
    a_write(1'b0, 24'hFF0000);
    a_write(1'b1, 24'h0000FF);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    check("t1_lat_n1_valid", 32'(a_valid), 32'd0);
    step();
    check("t1_valid", 32'(a_valid), 32'd1);
    check("t1_w0",    32'(a_data),  32'h00FF00);
    check("t1_last0", 32'(a_last),  32'd0);
    check("t1_go",    32'(a_go),    32'd1);
    check("t1_busy",  32'(a_busy),  32'd1);
    step();
    check("t1_hold", 32'(a_data), 32'h00FF00);
    a_ack = 1'b1; step(); a_ack = 1'b0;
    check("t1_w1",    32'(a_data), 32'h0000FF);
    check("t1_last1", 32'(a_last), 32'd1);
    a_ack = 1'b1; step(); a_ack = 1'b0;
    check("t1_drain_valid", 32'(a_valid), 32'd0);
    check("t1_drain_go",    32'(a_go),    32'd1);
    step();
    check("t1_drain_wait", 32'(a_go), 32'd1);
    a_idle = 1'b1; step(); a_idle = 1'b0;
    check("t1_latch_go",   32'(a_go),   32'd0);
    check("t1_latch_busy", 32'(a_busy), 32'd1);
    n = 0;
    while (a_busy && n < 50) begin
      step();
      n++;
    end
    check("t1_latch_len", 32'(n), 32'd10);
    repeat (3) step();
    check("t1_no_refire", 32'(a_valid), 32'd0);

    // Several requests during a frame collapse into one more frame
    a_start_frame();
    check("t2_valid", 32'(a_valid), 32'd1);
    repeat (3) begin
      a_start = 1'b1; step(); a_start = 1'b0; step();
    end
    check("t2_hold", 32'(a_data), 32'h00FF00);
    a_finish_frame();
    step();
    check("t2_extra_valid", 32'(a_valid), 32'd1);
    a_finish_frame();
    repeat (3) step();
    check("t2_no_third_valid", 32'(a_valid), 32'd0);
    check("t2_no_third_busy",  32'(a_busy),  32'd0);

    // Writes during a frame
    a_start_frame();
    check("t3_w0", 32'(a_data), 32'h00FF00);
    a_write(1'b1, 24'h123456);
    check("t3_hold_a", 32'(a_data), 32'h00FF00);
    a_write(1'b0, 24'hABCDEF);
    check("t3_hold_b", 32'(a_data), 32'h00FF00);
    a_ack = 1'b1; step(); a_ack = 1'b0;
    check("t3_w1_new", 32'(a_data), 32'h341256);
    check("t3_w1_last", 32'(a_last), 32'd1);
    a_finish_frame();

    // Write-first bypass and start coinciding with IDLE->SEND
    a_start = 1'b1;
    step();
    a_wr_en = 1'b1; a_wr_idx = 1'b0; a_wr_data = 24'h0A0B0C;
    step();
    a_start = 1'b0; a_wr_en = 1'b0;
    check("t3_byp_valid", 32'(a_valid), 32'd1);
    check("t3_byp_data",  32'(a_data),  32'h0B0A0C);
    a_finish_frame();
    step();
    check("t3_refire_valid", 32'(a_valid), 32'd1);
    check("t3_refire_data",  32'(a_data),  32'h0B0A0C);
    a_finish_frame();
    repeat (3) step();
    check("t3_no_third", 32'(a_valid), 32'd0);

    // Reset mid-frame with a request already queued
    a_start_frame();
    check("t5_pre_valid", 32'(a_valid), 32'd1);
    a_start = 1'b1; step(); a_start = 1'b0;
    a_rst = 1'b1; step(); a_rst = 1'b0;
    check("t5_busy",  32'(a_busy),  32'd0);
    check("t5_go",    32'(a_go),    32'd0);
    check("t5_valid", 32'(a_valid), 32'd0);
    check("t5_last",  32'(a_last),  32'd0);
    check("t5_data",  32'(a_data),  32'd0);
    repeat (5) step();
    check("t5_no_frame_valid", 32'(a_valid), 32'd0);
    check("t5_no_frame_busy",  32'(a_busy),  32'd0);
    a_start_frame();
    check("t5_tbl0_valid", 32'(a_valid), 32'd1);
    check("t5_tbl0", 32'(a_data), 32'd0);
    a_ack = 1'b1; step(); a_ack = 1'b0;
    check("t5_tbl1", 32'(a_data), 32'd0);
    check("t5_tbl1_last", 32'(a_last), 32'd1);
    a_finish_frame();

    // Auto-refresh, single-LED chain
    b_wr_en = 1'b1; b_wr_idx = 1'b0; b_wr_data = 24'h010203;
    step();
    b_wr_en = 1'b0;
    check("t4_lat_n1_valid", 32'(b_valid), 32'd0);
    step();
    check("t4_valid", 32'(b_valid), 32'd1);
    check("t4_data",  32'(b_data),  32'h020103);
    check("t4_last",  32'(b_last),  32'd1);
    b_ack = 1'b1; step(); b_ack = 1'b0;
    check("t4_drain_valid", 32'(b_valid), 32'd0);
    check("t4_drain_go",    32'(b_go),    32'd1);
    b_idle = 1'b1; step(); b_idle = 1'b0;
    n = 0;
    while (b_busy && n < 20) begin
      step();
      n++;
    end
    check("t4_latch_len", 32'(n), 32'd3);

    // Out-of-range write is dropped
    b_wr_en = 1'b1; b_wr_idx = 1'b1; b_wr_data = 24'hFFFFFF;
    step();
    b_wr_en = 1'b0;
    repeat (3) step();
    check("t6_no_pend_busy",  32'(b_busy),  32'd0);
    check("t6_no_pend_valid", 32'(b_valid), 32'd0);
    b_start = 1'b1; step(); b_start = 1'b0; step();
    check("t6_tbl_valid", 32'(b_valid), 32'd1);
    check("t6_tbl_kept",  32'(b_data),  32'h020103);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
